// File: rtl/y_alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package y_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_SLTU = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/y_mul_step.sv
// One shift-add iteration of an unsigned multiplier. The upper half of the
// product accumulates the multiplicand; the lower half starts as the multiplier
// and is consumed one bit per step from the LSB.
module y_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0] product_in,
    output logic [2*WIDTH-1:0] product_out
);

    logic [WIDTH:0] acc;

    // Conditionally add a into the upper half, keeping the carry, then shift right.
    always_comb begin
        acc = {1'b0, product_in[2*WIDTH-1:WIDTH]};
        if (product_in[0]) begin
            acc = acc + {1'b0, a};
        end
        product_out = {acc, product_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/y_alu_seq.sv
// Clocked ALU: single-cycle AND/OR/ADD/SUB/SLT/SLTU plus an iterative
// unsigned multiply producing a full 2*WIDTH product. Results and flags are
// registered together and held until the consumer accepts them.
module y_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_hi,
    output logic             zero,
    output logic             cout,
    output logic             ovf,
    output logic             ill
);

    import y_alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] step_out;
    logic [CNT_W-1:0]   count;

    // Single-cycle result path, computed from the live inputs at acceptance.
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_z;
    logic             sc_cout;
    logic             sc_ovf;
    logic             sc_ill;
    logic             slt_bit;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    y_mul_step #(.WIDTH(WIDTH)) u_step (
        .a           (a_r),
        .product_in  (product),
        .product_out (step_out)
    );

    // Shared add/sub adder feeding ADD, SUB, SLT and SLTU.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sc_z    = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        sub     = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff   = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        slt_bit = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
        case (op)
            OP_AND: sc_z = a & b;
            OP_OR:  sc_z = a | b;
            OP_ADD, OP_SUB: begin
                sc_z    = sum[WIDTH-1:0];
                sc_cout = sum[WIDTH];
                sc_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_z = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: sc_z = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            OP_RSVD: sc_ill = 1'b1;
            default: sc_z = '0;
        endcase
    end

    // Control FSM plus multiply datapath and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, datapath included, is reset so an aborted multiply leaves nothing behind.
        if (!rst_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            product <= '0;
            count   <= '0;
            z       <= '0;
            z_hi    <= '0;
            zero    <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            ill     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULU) begin
                            a_r     <= a;
                            product <= {{WIDTH{1'b0}}, b};
                            count   <= '0;
                            state   <= S_MUL;
                        end else begin
                            z     <= sc_z;
                            z_hi  <= '0;
                            zero  <= ~|sc_z;
                            cout  <= sc_cout;
                            ovf   <= sc_ovf;
                            ill   <= sc_ill;
                            state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    product <= step_out;
                    if (count == LAST_STEP) begin
                        z     <= step_out[WIDTH-1:0];
                        z_hi  <= step_out[2*WIDTH-1:WIDTH];
                        zero  <= ~|step_out;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        ill   <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_alu_seq.sv
// Self-checking bench for y_alu_seq: directed corner cases, multiply latency,
// backpressure, reset abort, randomized ops and an 8-bit build.
module tb_y_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z, z_hi;
    logic        zero, cout, ovf, ill;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [2:0]  op8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  z8, z_hi8;
    logic        zero8, cout8, ovf8, ill8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .z_hi(z_hi), .zero(zero), .cout(cout), .ovf(ovf), .ill(ill)
    );

    y_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .z(z8), .z_hi(z_hi8), .zero(zero8), .cout(cout8), .ovf(ovf8), .ill(ill8)
    );

    // Reference model: arithmetic on integers, flags from value ranges.
    function automatic void model(input int w, input logic [2:0] o,
                                  input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] ez, output logic [63:0] ezh,
                                  output logic [3:0] eflags);
        logic [63:0] m, full;
        longint sx, sy, s, lim;
        logic ecout, eovf, eill;
        m   = (64'd1 << w) - 64'd1;
        lim = longint'(1) << (w - 1);
        sx  = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy  = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        ez = '0; ezh = '0; ecout = 1'b0; eovf = 1'b0; eill = 1'b0;
        case (o)
            3'b000: ez = x & y;
            3'b001: ez = x | y;
            3'b010: begin
                full = x + y; ez = full & m; ecout = full[w];
                s = sx + sy; eovf = (s >= lim) || (s < -lim);
            end
            3'b110: begin
                ez = (x - y) & m; ecout = (x >= y);
                s = sx - sy; eovf = (s >= lim) || (s < -lim);
            end
            3'b111: ez = (sx < sy) ? 64'd1 : 64'd0;
            3'b100: ez = (x < y) ? 64'd1 : 64'd0;
            3'b011: begin full = x * y; ez = full & m; ezh = full >> w; end
            default: eill = 1'b1;
        endcase
        eflags = {(ez == 64'd0) && (ezh == 64'd0), ecout, eovf, eill};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present one bundle, scramble inputs after acceptance, wait for the result.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_hi);
        @(negedge clk);
        a = x; b = y; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        lat = 1; busy_hi = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_hi++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat);
        @(negedge clk);
        a8 = x; b8 = y; op8 = o; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1;
        while (out_valid8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        logic [68:0] got;
        #2 rst_n = 1'b0;
        #2;
        got = {out_valid, z_hi, z, zero, cout, ovf, ill};
        checks++;
        if (got !== '0) begin
            $display("FAIL reset_outputs got=%h exp=0", got);
            errors++;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL reset_release_handshake got=%b exp=10", {in_ready, out_valid});
            errors++;
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[10] = '{3'b010, 3'b110, 3'b111, 3'b100, 3'b101,
                                 3'b000, 3'b001, 3'b110, 3'b010, 3'b100};
        logic [31:0] xs[10]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'h1234_5678, 32'h0000_000C, 32'h0000_00F0, 32'h0000_0005,
                                 32'h7FFF_FFFF, 32'h0000_0001};
        logic [31:0] ys[10]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                 32'h9ABC_DEF0, 32'h0000_000A, 32'h0000_000F, 32'h0000_0005,
                                 32'h0000_0001, 32'hFFFF_FFFF};
        logic [63:0] ez, ezh;
        logic [3:0]  ef;
        int lat, busy;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], xs[i], ys[i], lat, busy);
            model(32, ops[i], {32'd0, xs[i]}, {32'd0, ys[i]}, ez, ezh, ef);
            checks++;
            if (lat != 1) begin
                $display("FAIL directed_latency[%0d] got=%0d exp=1", i, lat);
                errors++;
            end
            checks++;
            if ({z_hi, z, zero, cout, ovf, ill} !== {ezh[31:0], ez[31:0], ef}) begin
                $display("FAIL directed_result[%0d] op=%b got=%h_%h_%b exp=%h_%h_%b", i, ops[i],
                         z_hi, z, {zero, cout, ovf, ill}, ezh[31:0], ez[31:0], ef);
                errors++;
            end
            finish_op();
        end
    endtask

    task automatic test_mulu_latency();
        int lat, busy;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy);
        checks++;
        if (lat != 33) begin
            $display("FAIL mulu_latency got=%0d exp=33", lat);
            errors++;
        end
        checks++;
        if (busy != 0) begin
            $display("FAIL mulu_in_ready_low got=%0d_cycles_high exp=0", busy);
            errors++;
        end
        checks++;
        if ({z_hi, z, zero, cout, ovf, ill} !== {64'hFFFF_FFFE_0000_0001, 4'b0000}) begin
            $display("FAIL mulu_result got=%h_%h exp=fffffffe_00000001", z_hi, z);
            errors++;
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat, busy;
        issue(3'b001, 32'h0000_00F0, 32'h0000_000F, lat, busy);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid, in_ready, z_hi, z, zero, cout, ovf, ill} !==
                {2'b10, 32'h0, 32'h0000_00FF, 4'b0000}) begin
                $display("FAIL backpressure_hold[%0d] got=%b%b_%h_%h exp=10_0_ff",
                         i, out_valid, in_ready, z_hi, z);
                errors++;
            end
            @(posedge clk); #1;
        end
        finish_op();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL backpressure_release got=%b exp=10", {in_ready, out_valid});
            errors++;
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat, busy;
        @(negedge clk);
        a = $urandom; b = $urandom; op = 3'b011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, z_hi, z, zero, cout, ovf, ill} !== '0) begin
            $display("FAIL reset_mid_mul got=%b_%h_%h exp=0_0_0", out_valid, z_hi, z);
            errors++;
        end
        @(negedge clk); rst_n = 1'b1;
        issue(3'b000, 32'h0000_000C, 32'h0000_000A, lat, busy);
        checks++;
        if ({lat == 1, z_hi, z, zero, cout, ovf, ill} !== {1'b1, 32'h0, 32'h0000_0008, 4'b0000}) begin
            $display("FAIL after_reset_and got=lat%0d_%h_%h exp=lat1_0_8", lat, z_hi, z);
            errors++;
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] ez, ezh;
        logic [3:0]  ef;
        int lat, busy;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick32();
            y = pick32();
            issue(o, x, y, lat, busy);
            model(32, o, {32'd0, x}, {32'd0, y}, ez, ezh, ef);
            checks++;
            if (lat != ((o == 3'b011) ? 33 : 1)) begin
                $display("FAIL random_latency[%0d] op=%b got=%0d", i, o, lat);
                errors++;
            end
            checks++;
            if ({z_hi, z, zero, cout, ovf, ill} !== {ezh[31:0], ez[31:0], ef}) begin
                $display("FAIL random_result[%0d] op=%b a=%h b=%h got=%h_%h_%b exp=%h_%h_%b",
                         i, o, x, y, z_hi, z, {zero, cout, ovf, ill}, ezh[31:0], ez[31:0], ef);
                errors++;
            end
            finish_op();
        end
    endtask

    task automatic test_width8();
        logic [2:0]  o;
        logic [7:0]  x, y;
        logic [63:0] ez, ezh;
        logic [3:0]  ef;
        int lat;
        issue8(3'b011, 8'd200, 8'd200, lat);
        checks++;
        if (lat != 9 || {z_hi8, z8} !== 16'h9C40) begin
            $display("FAIL w8_mulu got=lat%0d_%h exp=lat9_9c40", lat, {z_hi8, z8});
            errors++;
        end
        finish_op();
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = 8'($urandom);
            issue8(o, x, y, lat);
            model(8, o, {56'd0, x}, {56'd0, y}, ez, ezh, ef);
            checks++;
            if (lat != ((o == 3'b011) ? 9 : 1) ||
                {z_hi8, z8, zero8, cout8, ovf8, ill8} !== {ezh[7:0], ez[7:0], ef}) begin
                $display("FAIL w8_random[%0d] op=%b a=%h b=%h got=lat%0d_%h_%h_%b exp=%h_%h_%b",
                         i, o, x, y, lat, z_hi8, z8, {zero8, cout8, ovf8, ill8},
                         ezh[7:0], ez[7:0], ef);
                errors++;
            end
            finish_op();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mulu_latency();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
